// File: rtl/iic_sched_pkg.sv
// Shared types and constants for the I2C access scheduler: FSM states, grant
// encoding and the ADXL345 register map entries used by the poll/config paths.
package iic_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_CFG  = 1'b0,
        GRANT_POLL = 1'b1
    } grant_e;

    localparam logic [7:0] DATAX0    = 8'h32;
    localparam logic [7:0] POWER_CTL = 8'h2D;

    function automatic logic is_last_beat(input logic [7:0] cnt, input logic [7:0] len);
        return (cnt == (len - 8'd1));
    endfunction

endpackage

// File: rtl/iic_rr_arb2.sv
// Two-requester round-robin arbiter (config writes vs. poll reads); the
// remembered last grant powers up as POLL so the first tie goes to CFG.
module iic_rr_arb2
    import iic_sched_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   i_en,
    input  logic   i_req_cfg,
    input  logic   i_req_poll,
    output logic   o_gnt_valid,
    output grant_e o_gnt
);

    grant_e r_last;

    // Grant decision: alternate on a tie, otherwise serve whoever is asking.
    always_comb begin
        o_gnt_valid = i_en & (i_req_cfg | i_req_poll);
        o_gnt       = GRANT_POLL;
        if (i_req_cfg && i_req_poll) begin
            o_gnt = (r_last == GRANT_POLL) ? GRANT_CFG : GRANT_POLL;
        end else if (i_req_cfg) begin
            o_gnt = GRANT_CFG;
        end else begin
            o_gnt = GRANT_POLL;
        end
    end

    // Last-grant memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= GRANT_POLL;
        end else if (o_gnt_valid) begin
            r_last <= o_gnt;
        end else begin
            r_last <= r_last;
        end
    end

endmodule

// File: rtl/iic_access_scheduler.sv
// Schedules register writes and periodic burst reads onto one I2C master.
// Define POLL_TIMER_EN to generate poll triggers internally instead of poll_req.
module iic_access_scheduler
    import iic_sched_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h53,
    parameter logic [7:0] POLL_PTR    = DATAX0,
    parameter int         POLL_LEN    = 6,
    parameter int         POLL_PERIOD = 100000,
    parameter int         TIMEOUT     = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_req,
    input  logic [7:0] cfg_addr,
    input  logic [7:0] cfg_data,
    output logic       cfg_ack,
    input  logic       poll_req,
    output logic       m_cmd_valid,
    input  logic       m_cmd_ready,
    output logic       m_cmd_rw,
    output logic [6:0] m_cmd_dev,
    output logic [7:0] m_cmd_ptr,
    output logic [7:0] m_cmd_len,
    output logic [7:0] m_cmd_wdata,
    input  logic       m_rsp_valid,
    input  logic [7:0] m_rsp_data,
    input  logic       m_done,
    input  logic       m_nack,
    output logic       s_smp_valid,
    output logic [7:0] s_smp_data,
    output logic       s_smp_last,
    output logic       err,
    output logic       poll_overrun,
    output logic       busy
);

    localparam int         TW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [7:0] LEN_B   = 8'(POLL_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e        r_state;
    state_e        w_next;
    logic          w_trig;
    logic          w_arb_en;
    logic          w_gnt_valid;
    grant_e        w_gnt;
    logic          w_poll_clr;
    logic          w_accept;
    logic          w_tmo_hit;
    logic          r_poll_pending;
    logic          r_overrun;
    logic          r_err;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_cnt;
    logic          r_cmd_rw;
    logic [6:0]    r_cmd_dev;
    logic [7:0]    r_cmd_ptr;
    logic [7:0]    r_cmd_len;
    logic [7:0]    r_cmd_wdata;
    logic          r_smp_valid;
    logic [7:0]    r_smp_data;
    logic          r_smp_last;

`ifdef POLL_TIMER_EN
    logic [31:0] r_ptmr;

    // Free-running poll period counter; fires on its last count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptmr <= 32'd0;
        end else if (r_ptmr == 32'(POLL_PERIOD - 1)) begin
            r_ptmr <= 32'd0;
        end else begin
            r_ptmr <= r_ptmr + 32'd1;
        end
    end

    assign w_trig = (r_ptmr == 32'(POLL_PERIOD - 1));
`else
    assign w_trig = poll_req;
`endif

    assign w_arb_en   = (r_state == ST_IDLE) && !reset;
    assign w_poll_clr = w_gnt_valid && (w_gnt == GRANT_POLL);
    assign w_accept   = (r_state == ST_CMD) && m_cmd_ready;
    assign w_tmo_hit  = (r_state == ST_WAIT) && !m_done && (r_tmo == TMO_LAST);

    iic_rr_arb2 u_arb (
        .clk         (clk),
        .reset       (reset),
        .i_en        (w_arb_en),
        .i_req_cfg   (cfg_req),
        .i_req_poll  (r_poll_pending),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt       (w_gnt)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_valid) w_next = ST_CMD;
                else             w_next = ST_IDLE;
            end
            ST_CMD: begin
                if (m_cmd_ready) w_next = ST_WAIT;
                else             w_next = ST_CMD;
            end
            ST_WAIT: begin
                if (m_done || w_tmo_hit) w_next = ST_IDLE;
                else                     w_next = ST_WAIT;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Poll request bookkeeping: a trigger racing its own grant re-arms pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_poll_pending <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_poll_pending <= w_trig | (r_poll_pending & ~w_poll_clr);
            r_overrun      <= w_trig & r_poll_pending & ~w_poll_clr;
        end
    end

    // Command field capture on grant; fields stay stable through CMD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_rw    <= 1'b0;
            r_cmd_dev   <= 7'd0;
            r_cmd_ptr   <= 8'd0;
            r_cmd_len   <= 8'd0;
            r_cmd_wdata <= 8'd0;
        end else if (w_gnt_valid && (w_gnt == GRANT_CFG)) begin
            r_cmd_rw    <= 1'b0;
            r_cmd_dev   <= DEV_ADDR;
            r_cmd_ptr   <= cfg_addr;
            r_cmd_len   <= 8'd1;
            r_cmd_wdata <= cfg_data;
        end else if (w_gnt_valid) begin
            r_cmd_rw    <= 1'b1;
            r_cmd_dev   <= DEV_ADDR;
            r_cmd_ptr   <= POLL_PTR;
            r_cmd_len   <= LEN_B;
            r_cmd_wdata <= 8'd0;
        end else begin
            r_cmd_rw    <= r_cmd_rw;
            r_cmd_dev   <= r_cmd_dev;
            r_cmd_ptr   <= r_cmd_ptr;
            r_cmd_len   <= r_cmd_len;
            r_cmd_wdata <= r_cmd_wdata;
        end
    end

    // Timeout counter: cleared on acceptance, counts every WAIT cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo <= '0;
        end else if (w_accept) begin
            r_tmo <= '0;
        end else if (r_state == ST_WAIT) begin
            r_tmo <= r_tmo + TW'(1);
        end else begin
            r_tmo <= r_tmo;
        end
    end

    // Read-beat forwarding with byte counter; beats past the burst are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= 8'd0;
            r_smp_valid <= 1'b0;
            r_smp_data  <= 8'd0;
            r_smp_last  <= 1'b0;
        end else if (w_accept) begin
            r_cnt       <= 8'd0;
            r_smp_valid <= 1'b0;
            r_smp_data  <= 8'd0;
            r_smp_last  <= 1'b0;
        end else if ((r_state == ST_WAIT) && m_rsp_valid && r_cmd_rw && (r_cnt < LEN_B)) begin
            r_cnt       <= r_cnt + 8'd1;
            r_smp_valid <= 1'b1;
            r_smp_data  <= m_rsp_data;
            r_smp_last  <= is_last_beat(r_cnt, LEN_B);
        end else begin
            r_cnt       <= r_cnt;
            r_smp_valid <= 1'b0;
            r_smp_data  <= 8'd0;
            r_smp_last  <= 1'b0;
        end
    end

    // Error pulse on NACKed completion or on timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= ((r_state == ST_WAIT) && m_done && m_nack) | w_tmo_hit;
        end
    end

    assign cfg_ack      = w_gnt_valid && (w_gnt == GRANT_CFG);
    assign busy         = (r_state != ST_IDLE);
    assign m_cmd_valid  = (r_state == ST_CMD);
    assign m_cmd_rw     = r_cmd_rw;
    assign m_cmd_dev    = r_cmd_dev;
    assign m_cmd_ptr    = r_cmd_ptr;
    assign m_cmd_len    = r_cmd_len;
    assign m_cmd_wdata  = r_cmd_wdata;
    assign s_smp_valid  = r_smp_valid;
    assign s_smp_data   = r_smp_data;
    assign s_smp_last   = r_smp_last;
    assign err          = r_err;
    assign poll_overrun = r_overrun;

endmodule

// File: tb/tb_iic_access_scheduler.sv
// Directed self-checking bench for iic_access_scheduler (TIMEOUT=16, poll_req trigger).
module tb_iic_access_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cfg_req = 1'b0;
    logic [7:0] cfg_addr = 8'd0;
    logic [7:0] cfg_data = 8'd0;
    logic       cfg_ack;
    logic       poll_req = 1'b0;
    logic       m_cmd_valid;
    logic       m_cmd_ready = 1'b1;
    logic       m_cmd_rw;
    logic [6:0] m_cmd_dev;
    logic [7:0] m_cmd_ptr;
    logic [7:0] m_cmd_len;
    logic [7:0] m_cmd_wdata;
    logic       m_rsp_valid = 1'b0;
    logic [7:0] m_rsp_data = 8'd0;
    logic       m_done = 1'b0;
    logic       m_nack = 1'b0;
    logic       s_smp_valid;
    logic [7:0] s_smp_data;
    logic       s_smp_last;
    logic       err;
    logic       poll_overrun;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_ovr    = 0;
    logic [8:0] cmd_q[$];

    iic_access_scheduler #(
        .DEV_ADDR    (7'h53),
        .POLL_PTR    (8'h32),
        .POLL_LEN    (6),
        .POLL_PERIOD (100000),
        .TIMEOUT     (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_req      (cfg_req),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_ack      (cfg_ack),
        .poll_req     (poll_req),
        .m_cmd_valid  (m_cmd_valid),
        .m_cmd_ready  (m_cmd_ready),
        .m_cmd_rw     (m_cmd_rw),
        .m_cmd_dev    (m_cmd_dev),
        .m_cmd_ptr    (m_cmd_ptr),
        .m_cmd_len    (m_cmd_len),
        .m_cmd_wdata  (m_cmd_wdata),
        .m_rsp_valid  (m_rsp_valid),
        .m_rsp_data   (m_rsp_data),
        .m_done       (m_done),
        .m_nack       (m_nack),
        .s_smp_valid  (s_smp_valid),
        .s_smp_data   (s_smp_data),
        .s_smp_last   (s_smp_last),
        .err          (err),
        .poll_overrun (poll_overrun),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Record accepted commands and overrun pulses.
    always @(negedge clk) begin
        if (!reset && m_cmd_valid && m_cmd_ready) cmd_q.push_back({m_cmd_rw, m_cmd_ptr});
        if (poll_overrun) n_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] q_rw(input int idx);
        if (idx < cmd_q.size()) return {31'd0, cmd_q[idx][8]};
        return 32'hFF;
    endfunction

    // Wait (bounded) for a command, let it be accepted, then complete it.
    task automatic serve_one();
        for (int n = 0; n < 50 && !m_cmd_valid; n++) @(negedge clk);
        check("cmd_seen", {31'd0, m_cmd_valid}, 32'd1);
        @(negedge clk);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
    endtask

    // Keep completing transactions until cfg_ack shows up (bounded).
    task automatic run_until_ack();
        logic got;
        got = 1'b0;
        #1;
        for (int n = 0; n < 60 && !got; n++) begin
            if (cfg_ack) begin
                got = 1'b1;
            end else begin
                m_done = busy & ~m_cmd_valid;
                @(negedge clk);
                m_done = 1'b0;
                #1;
            end
        end
        check("ack_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cmd_q.delete();
    endtask

    initial begin
        // Reset: outputs quiet even with a request present
        cfg_req = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, m_cmd_valid}, 32'd0);
        check("rst_ack",   {31'd0, cfg_ack}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_dev",   {25'd0, m_cmd_dev}, 32'd0);
        cfg_req = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Single CFG write
        cfg_req = 1'b1; cfg_addr = 8'h2D; cfg_data = 8'h08;
        #1;
        check("cfg_ack_pulse", {31'd0, cfg_ack}, 32'd1);
        @(negedge clk);
        cfg_req = 1'b0;
        #1;
        check("cfg_ack_once", {31'd0, cfg_ack}, 32'd0);
        check("cfg_valid", {31'd0, m_cmd_valid}, 32'd1);
        check("cfg_rw",    {31'd0, m_cmd_rw}, 32'd0);
        check("cfg_dev",   {25'd0, m_cmd_dev}, 32'h53);
        check("cfg_ptr",   {24'd0, m_cmd_ptr}, 32'h2D);
        check("cfg_len",   {24'd0, m_cmd_len}, 32'd1);
        check("cfg_wdata", {24'd0, m_cmd_wdata}, 32'h08);
        @(negedge clk);
        check("cfg_wait_busy",  {31'd0, busy}, 32'd1);
        check("cfg_wait_valid", {31'd0, m_cmd_valid}, 32'd0);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        check("cfg_done_busy", {31'd0, busy}, 32'd0);
        check("cfg_done_err",  {31'd0, err}, 32'd0);

        // Poll read: 6 beats forwarded, a 7th beat dropped
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
        @(negedge clk);
        check("poll_valid", {31'd0, m_cmd_valid}, 32'd1);
        check("poll_rw",    {31'd0, m_cmd_rw}, 32'd1);
        check("poll_ptr",   {24'd0, m_cmd_ptr}, 32'h32);
        check("poll_len",   {24'd0, m_cmd_len}, 32'd6);
        check("poll_wdata", {24'd0, m_cmd_wdata}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            m_rsp_valid = 1'b1;
            m_rsp_data  = 8'(i + 1);
            @(negedge clk);
            if (i < 6) begin
                check("smp_valid", {31'd0, s_smp_valid}, 32'd1);
                check("smp_data",  {24'd0, s_smp_data}, 32'(i + 1));
                check("smp_last",  {31'd0, s_smp_last}, (i == 5) ? 32'd1 : 32'd0);
            end else begin
                check("smp_drop", {31'd0, s_smp_valid}, 32'd0);
            end
        end
        m_rsp_valid = 1'b0;
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        check("poll_done_busy", {31'd0, busy}, 32'd0);

        // Ties after reset: CFG first, then CFG first again, then POLL after a lone CFG
        do_reset();
        for (int t = 0; t < 2; t++) begin
            cmd_q.delete();
            poll_req = 1'b1;
            @(negedge clk);
            poll_req = 1'b0;
            cfg_req = 1'b1; cfg_addr = 8'h2C; cfg_data = 8'h0A;
            #1;
            check("tie_cfg_first", {31'd0, cfg_ack}, 32'd1);
            @(negedge clk);
            cfg_req = 1'b0;
            @(negedge clk);
            m_done = 1'b1;
            @(negedge clk);
            m_done = 1'b0;
            serve_one();
            check("tie_order0", q_rw(0), 32'd0);
            check("tie_order1", q_rw(1), 32'd1);
        end
        cfg_req = 1'b1;
        run_until_ack();
        @(negedge clk);
        cfg_req = 1'b0;
        @(negedge clk);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        cmd_q.delete();
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
        cfg_req = 1'b1;
        #1;
        check("tie_poll_turn", {31'd0, cfg_ack}, 32'd0);
        @(negedge clk);
        run_until_ack();
        @(negedge clk);
        cfg_req = 1'b0;
        serve_one();
        check("tie3_order0", q_rw(0), 32'd1);
        check("tie3_order1", q_rw(1), 32'd0);

        // Two triggers while busy: one overrun, one poll command
        repeat (2) @(negedge clk);
        cmd_q.delete();
        n_ovr = 0;
        cfg_req = 1'b1;
        #1;
        @(negedge clk);
        cfg_req = 1'b0;
        @(negedge clk);
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
        @(negedge clk);
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
        @(negedge clk);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
        serve_one();
        repeat (5) @(negedge clk);
        check("ovr_count", n_ovr, 32'd1);
        check("ovr_cmds",  cmd_q.size(), 32'd2);
        check("ovr_poll",  q_rw(1), 32'd1);

        // Timeout: err 16 edges after the accepting edge
        cfg_req = 1'b1;
        #1;
        @(negedge clk);
        cfg_req = 1'b0;
        check("tmo_accept", {31'd0, m_cmd_valid}, 32'd1);
        repeat (16) @(negedge clk);
        check("tmo_early_err",  {31'd0, err}, 32'd0);
        check("tmo_early_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("tmo_err",  {31'd0, err}, 32'd1);
        check("tmo_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("tmo_err_pulse", {31'd0, err}, 32'd0);

        // NACK on completion
        cfg_req = 1'b1;
        #1;
        @(negedge clk);
        cfg_req = 1'b0;
        @(negedge clk);
        m_done = 1'b1; m_nack = 1'b1;
        @(negedge clk);
        m_done = 1'b0; m_nack = 1'b0;
        check("nack_err",  {31'd0, err}, 32'd1);
        check("nack_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("nack_err_pulse", {31'd0, err}, 32'd0);

        // Reset in WAIT with a poll pending
        cfg_req = 1'b1;
        #1;
        @(negedge clk);
        cfg_req = 1'b0;
        @(negedge clk);
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy",  {31'd0, busy}, 32'd0);
        check("mid_rst_valid", {31'd0, m_cmd_valid}, 32'd0);
        reset = 1'b0;
        cmd_q.delete();
        repeat (5) @(negedge clk);
        check("post_rst_cmds", cmd_q.size(), 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iic_access_scheduler.md
IIC_ACCESS_SCHEDULER -- requirements
Module: iic_access_scheduler

Interface
REQ-001 SHALL have parameter DEV_ADDR, 7'h53: 7-bit I2C device address placed on every command.
REQ-002 SHALL have parameter POLL_PTR, 8'h32: first register of the poll burst read.
REQ-003 SHALL have parameter POLL_LEN, 6: poll burst length in bytes, legal range 1..255.
REQ-004 SHALL have parameter POLL_PERIOD, 100000: poll timer period in clk cycles, minimum 2.
REQ-005 SHALL have parameter TIMEOUT, 65535: maximum cycles to wait for m_done after command acceptance.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have ports cfg_req / cfg_addr / cfg_data, input, 1/8/8: register-write request, held until cfg_ack; address; data.
REQ-009 SHALL have port cfg_ack, output, 1: one-cycle pulse; cfg_addr/cfg_data are sampled in this cycle.
REQ-010 SHALL have port poll_req, input, 1: external poll trigger pulse; ignored when POLL_TIMER_EN is defined.
REQ-011 SHALL have ports m_cmd_valid / m_cmd_ready / m_cmd_rw / m_cmd_dev / m_cmd_ptr / m_cmd_len / m_cmd_wdata, out/in/out/out/out/out/out, 1/1/1/7/8/8/8: command to the I2C master; rw=1 is read.
REQ-012 SHALL have ports m_rsp_valid / m_rsp_data, input, 1/8: read-data beats from the master.
REQ-013 SHALL have ports m_done / m_nack, input, 1/1: transaction end pulse; nack is qualified by m_done.
REQ-014 SHALL have ports s_smp_valid / s_smp_data / s_smp_last, output, 1/8/1: forwarded poll bytes; last marks byte POLL_LEN.
REQ-015 SHALL have ports err / poll_overrun / busy, output, 1/1/1: NACK-or-timeout pulse; dropped-poll pulse; FSM not IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> CMD -> WAIT -> IDLE.
REQ-017 IDLE: on any pending request, grant in the same cycle and go to CMD on the next cycle.
REQ-018 Arbitration SHALL be round-robin: if both are pending, grant the requester not granted last; after reset the last grant is POLL, so the first tie goes to CFG.
REQ-019 A CFG grant SHALL pulse cfg_ack and latch addr/data; the command is rw=0, ptr=cfg_addr, len=1, wdata=cfg_data.
REQ-020 A POLL grant SHALL clear poll_pending; the command is rw=1, ptr=POLL_PTR, len=POLL_LEN, wdata=0.
REQ-021 CMD: m_cmd_valid SHALL be 1 and the fields stable until m_cmd_valid & m_cmd_ready, then go to WAIT.
REQ-022 WAIT: each m_rsp_valid SHALL appear on s_smp_* exactly one cycle later (registered); a byte counter asserts s_smp_last on beat POLL_LEN; beats beyond POLL_LEN SHALL be dropped.
REQ-023 WAIT: m_done SHALL return to IDLE; if m_nack=1, pulse err in the next cycle.
REQ-024 WAIT: the timeout counter starts at 0 on entry; reaching TIMEOUT with no m_done SHALL pulse err and return to IDLE.
REQ-025 poll_pending SHALL be set by a poll trigger; a trigger while already pending SHALL pulse poll_overrun and leave pending set.
REQ-026 A trigger in the same cycle as the POLL grant SHALL leave poll_pending set, with no overrun.
REQ-027 busy SHALL be 1 in CMD and WAIT.

Reset
REQ-028 Reset SHALL force IDLE, clear poll_pending, byte counter, timeout counter and poll timer, set last grant to POLL, and drive all outputs to 0, including a reset asserted mid-transaction.

Configuration
REQ-029 With POLL_TIMER_EN defined, an internal counter SHALL produce a trigger every POLL_PERIOD cycles, first at cycle POLL_PERIOD after reset release, and poll_req is unused.
REQ-030 Without POLL_TIMER_EN, the timer logic SHALL be absent and the trigger is poll_req.

Structure
REQ-031 Package iic_sched_pkg SHALL hold the FSM state enum, the grant enum (GRANT_CFG, GRANT_POLL) and the ADXL345 register constants (DATAX0=8'h32, POWER_CTL=8'h2D).
REQ-032 The round-robin arbiter SHALL be sub-module iic_rr_arb2.

Verification
REQ-033 Single CFG write: cfg_req with addr 8'h2D, data 8'h08, m_cmd_ready=1 -> cfg_ack one cycle, command rw=0 ptr=8'h2D len=1 wdata=8'h08, busy until m_done.
REQ-034 Poll read: trigger, master returns 6 bytes 01..06 -> s_smp_data 01..06 each one cycle after its beat, s_smp_last only on 06.
REQ-035 Simultaneous cfg_req and trigger after reset -> CFG served first, POLL second; repeat the tie -> CFG first again.
REQ-036 Two triggers during a busy transaction -> one poll_overrun pulse, exactly one poll command afterwards.
REQ-037 TIMEOUT=16 with no m_done -> err pulses 16 cycles after acceptance, FSM IDLE; m_done with m_nack=1 -> err pulse.
REQ-038 Reset asserted in WAIT -> next cycle busy=0, m_cmd_valid=0, no pending requests.
